// File: rtl/noc_pkg.sv
// Shared NoC flit format: field positions, flit type encodings and credit width.
package noc_pkg;

  localparam int FLIT_W     = 73;
  localparam int VALID_BIT  = 72;
  localparam int TYPE_HI    = 71;
  localparam int TYPE_LO    = 70;
  localparam int DST_HI     = 69;
  localparam int DST_LO     = 65;
  localparam int RSVD_BIT   = 64;
  localparam int HDR_SRC_HI = 63;
  localparam int HDR_SRC_LO = 56;
  localparam int HDR_DST_HI = 55;
  localparam int HDR_DST_LO = 48;
  localparam int HDR_LEN_HI = 47;
  localparam int HDR_LEN_LO = 42;
  localparam int HDR_ID_HI  = 41;
  localparam int HDR_ID_LO  = 36;
  localparam int DATA_HI    = 31;
  localparam int DATA_LO    = 0;

  localparam int CREDIT_W = 3;
  localparam int NODE_W   = 5;
  localparam int ADDR_W   = 8;
  localparam int SEQ_W    = 6;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    FLIT_HEAD = 2'b00,
    FLIT_BODY = 2'b01,
    FLIT_TAIL = 2'b10,
    FLIT_RSVD = 2'b11
  } flit_type_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_BODY = 1'b1
  } rx_state_e;

  function automatic flit_type_e flitType(input logic [1:0] typeBits);
    return flit_type_e'(typeBits);
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// DEPTH-entry synchronous flit FIFO; the front entry is visible combinationally on rdata_o.
module flit_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FLIT_W
) (
  input  logic                   N_clk,
  input  logic                   N_rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  // A push into a full FIFO is only legal when the same edge frees a slot.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  always_ff @(posedge N_clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge N_clk or negedge N_rst_n) begin
    if (!N_rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/node_eject_rx.sv
// Ejection receiver: buffers router flits, returns one credit per freed slot, and turns
// head/body/tail packets into a 32-bit word stream with packet metadata for the PE.
module node_eject_rx
  import noc_pkg::*;
#(
  parameter int                  DEPTH = 4,
  parameter logic [CREDIT_W-1:0] VC_ID = '0
) (
  input  logic                N_clk,
  input  logic                N_rst_n,
  input  logic [NODE_W-1:0]   node_number,
  input  logic [FLIT_W-1:0]   input_flit,
  output logic [CREDIT_W-1:0] out_credit,
  output logic                out_credit_valid,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_data_valid,
  input  logic                i_data_ready,
  output logic                o_last,
  output logic [ADDR_W-1:0]   o_src,
  output logic [SEQ_W-1:0]    o_seq_len,
  output logic [SEQ_W-1:0]    o_id,
  output logic                o_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  rx_state_e           state_q, state_d;
  logic [FLIT_W-1:0]   frontFlit;
  logic [CNT_W-1:0]    fifoCount;
  logic                fifoFull, fifoEmpty, fifoPush, fifoPop, overflow;
  flit_type_e          frontType;
  logic [ADDR_W-1:0]   hdrSrc, hdrDst;
  logic [SEQ_W-1:0]    hdrLen, hdrId;
  logic [DATA_W-1:0]   frontData;
  logic                headPop, emitWord, emitLast, protoErr;
  logic [SEQ_W-1:0]    wordCnt_q, wordCnt_d, cntInc;
  logic [ADDR_W-1:0]   pktSrc_q;
  logic [SEQ_W-1:0]    pktLen_q, pktId_q;
  logic                dataValid_q, last_q, creditValid_q, err_q;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W-1:0]   src_q;
  logic [SEQ_W-1:0]    seqLen_q, id_q;
  logic [CREDIT_W-1:0] credit_q;
  logic                unusedFrontBits;

  flit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FLIT_W)
  ) u_fifo (
    .N_clk   (N_clk),
    .N_rst_n (N_rst_n),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .wdata_i (input_flit),
    .rdata_o (frontFlit),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign frontType = flitType(frontFlit[TYPE_HI:TYPE_LO]);
  assign hdrSrc    = frontFlit[HDR_SRC_HI:HDR_SRC_LO];
  assign hdrDst    = frontFlit[HDR_DST_HI:HDR_DST_LO];
  assign hdrLen    = frontFlit[HDR_LEN_HI:HDR_LEN_LO];
  assign hdrId     = frontFlit[HDR_ID_HI:HDR_ID_LO];
  assign frontData = frontFlit[DATA_HI:DATA_LO];
  assign cntInc    = wordCnt_q + SEQ_W'(1);

  assign unusedFrontBits = ^{frontFlit[VALID_BIT], frontFlit[DST_HI:DST_LO],
                             frontFlit[RSVD_BIT], frontFlit[HDR_ID_LO-1:DATA_HI+1]};

  // Heads and reserved flits never need the output register, so they drain regardless of ready.
  assign fifoPop  = !fifoEmpty && ((frontType == FLIT_HEAD) || (frontType == FLIT_RSVD) ||
                                   !dataValid_q || i_data_ready);
  assign fifoPush = input_flit[VALID_BIT] && ((fifoCount < CNT_W'(DEPTH)) || fifoPop);
  assign overflow = input_flit[VALID_BIT] && fifoFull && !fifoPop;

  always_ff @(posedge N_clk or negedge N_rst_n) begin
    if (!N_rst_n) state_q <= RX_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (fifoPop) begin
      case (frontType)
        FLIT_HEAD: state_d = RX_BODY;
        FLIT_TAIL: state_d = RX_IDLE;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    headPop  = 1'b0;
    emitWord = 1'b0;
    emitLast = 1'b0;
    protoErr = 1'b0;
    if (fifoPop) begin
      case (frontType)
        FLIT_HEAD: begin
          headPop  = 1'b1;
          protoErr = (state_q == RX_BODY) || (hdrDst != {3'b000, node_number});
        end
        FLIT_BODY, FLIT_TAIL: begin
          if (state_q == RX_BODY) begin
            emitWord = 1'b1;
            emitLast = (frontType == FLIT_TAIL);
            protoErr = (frontType == FLIT_TAIL) && (cntInc != pktLen_q);
          end else begin
            protoErr = 1'b1;
          end
        end
        default: protoErr = 1'b1;
      endcase
    end
  end

  always_comb begin
    wordCnt_d = wordCnt_q;
    if (headPop)       wordCnt_d = '0;
    else if (emitWord) wordCnt_d = cntInc;
  end

  always_ff @(posedge N_clk or negedge N_rst_n) begin
    if (!N_rst_n) begin
      wordCnt_q <= '0;
      pktSrc_q  <= '0;
      pktLen_q  <= '0;
      pktId_q   <= '0;
    end else begin
      wordCnt_q <= wordCnt_d;
      if (headPop) begin
        pktSrc_q <= hdrSrc;
        pktLen_q <= hdrLen;
        pktId_q  <= hdrId;
      end
    end
  end

  // Metadata follows a new head early only when no unconsumed word is being held.
  always_ff @(posedge N_clk or negedge N_rst_n) begin
    if (!N_rst_n) begin
      dataValid_q <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      src_q       <= '0;
      seqLen_q    <= '0;
      id_q        <= '0;
    end else if (emitWord) begin
      dataValid_q <= 1'b1;
      data_q      <= frontData;
      last_q      <= emitLast;
      src_q       <= pktSrc_q;
      seqLen_q    <= pktLen_q;
      id_q        <= pktId_q;
    end else begin
      if (dataValid_q && i_data_ready) dataValid_q <= 1'b0;
      if (headPop && (!dataValid_q || i_data_ready)) begin
        src_q    <= hdrSrc;
        seqLen_q <= hdrLen;
        id_q     <= hdrId;
      end
    end
  end

  always_ff @(posedge N_clk or negedge N_rst_n) begin
    if (!N_rst_n) begin
      creditValid_q <= 1'b0;
      credit_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      creditValid_q <= fifoPop;
      credit_q      <= fifoPop ? VC_ID : '0;
      err_q         <= err_q | overflow | protoErr;
    end
  end

  assign out_credit       = credit_q;
  assign out_credit_valid = creditValid_q;
  assign o_data           = data_q;
  assign o_data_valid     = dataValid_q;
  assign o_last           = last_q;
  assign o_src            = src_q;
  assign o_seq_len        = seqLen_q;
  assign o_id             = id_q;
  assign o_err            = err_q;

endmodule
